set_time_ctrl: RTL and testbench

- User time-setting front end for the clock: the input direction complementing the counter/display output path.
- Debounces raw mode/increment buttons, walks an edit FSM over hours then minutes, and emits a one-cycle BCD load strobe to the hour/minute/second counters.
- Drives blank masks so the display blinks the field under edit.
- Sits beside the 1 Hz divisor and reuses its enable_1hz tick.

---
 rtl/clock_pkg.sv | 57 +++++
 rtl/debounce_btn.sv | 55 +++++
 rtl/set_time_ctrl.sv | 160 ++++++++++++++++
 tb/tb_set_time_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clock_pkg : shared edit-FSM state type and BCD increment helpers   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] msd;
        logic [3:0] lsd;
    } bcd2_t;

    localparam logic [2:0] HOUR_MAX_MSD      = 3'd2;
    localparam logic [3:0] HOUR_MAX_LSD_AT_2 = 4'd3;
    localparam logic [2:0] MIN_MAX_MSD       = 3'd5;
    localparam logic [3:0] BCD_MAX           = 4'd9;

    // Anything at or past 23 (including garbage loaded from the counters) wraps to 00.
    function automatic bcd2_t hour_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if ((v.msd > HOUR_MAX_MSD) || (v.lsd > BCD_MAX) ||
            ((v.msd == HOUR_MAX_MSD) && (v.lsd >= HOUR_MAX_LSD_AT_2))) begin
            r = '0;
        end else if (v.lsd == BCD_MAX) begin
            r.msd = v.msd + 3'd1;
            r.lsd = 4'd0;
        end else begin
            r.lsd = v.lsd + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t min_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if ((v.msd > MIN_MAX_MSD) || (v.lsd > BCD_MAX) ||
            ((v.msd == MIN_MAX_MSD) && (v.lsd == BCD_MAX))) begin
            r = '0;
        end else if (v.lsd == BCD_MAX) begin
            r.msd = v.msd + 3'd1;
            r.lsd = 4'd0;
        end else begin
            r.lsd = v.lsd + 4'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_btn.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_btn : 2-FF sync, stability counter, rising-edge press     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module debounce_btn #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic main_clock,
    input  logic main_reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;

    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // The level flips on the DEB_CYCLES-th consecutive differing sample.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/set_time_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | set_time_ctrl : button-driven hour/minute edit FSM with BCD load    |
// | Optional AUTO_REPEAT_EN: held inc repeats once per second. Rev 1.0  |
// +------------------------------------------------------------------+
module set_time_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic       enable_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [2:0] cur_h_msd,
    input  logic [3:0] cur_h_lsd,
    input  logic [2:0] cur_m_msd,
    input  logic [3:0] cur_m_lsd,
    output logic       load,
    output logic [2:0] ld_h_msd,
    output logic [3:0] ld_h_lsd,
    output logic [2:0] ld_m_msd,
    output logic [3:0] ld_m_lsd,
    output logic       edit_active,
    output logic       blank_h,
    output logic       blank_m
);

    localparam int TW = $clog2(TIMEOUT_S + 1);

    logic          w_mode_press, w_mode_level;
    logic          w_inc_press, w_inc_level;
    logic          w_rep_ev, w_mode_ev, w_inc_ev;
    logic          w_editing, w_timeout;
    logic          w_unused;
    state_t        r_state, w_next;
    bcd2_t         r_eh, r_em, w_eh_n, w_em_n;
    bcd2_t         r_ld_h, r_ld_m;
    logic          r_load;
    logic [TW-1:0] r_to;
    logic          r_phase;

    debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .main_clock (main_clock),
        .main_reset (main_reset),
        .raw        (btn_mode),
        .level      (w_mode_level),
        .press      (w_mode_press)
    );

    debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .main_clock (main_clock),
        .main_reset (main_reset),
        .raw        (btn_inc),
        .level      (w_inc_level),
        .press      (w_inc_press)
    );

    assign w_unused  = &{1'b0, w_mode_level, w_inc_level};
    assign w_editing = (r_state == EDIT_H) || (r_state == EDIT_M);

`ifdef AUTO_REPEAT_EN
    logic [1:0] r_hold;

    // Two full ticks of holding arm the repeat; every later tick fires one.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            r_hold <= 2'd0;
        end else if (!w_editing || !w_inc_level) begin
            r_hold <= 2'd0;
        end else if (enable_1hz && (r_hold != 2'd2)) begin
            r_hold <= r_hold + 2'd1;
        end
    end

    assign w_rep_ev = w_editing & w_inc_level & enable_1hz & (r_hold == 2'd2);
`else
    assign w_rep_ev = 1'b0;
`endif

    assign w_mode_ev = w_mode_press;
    assign w_inc_ev  = (w_inc_press | w_rep_ev) & ~w_mode_press;
    assign w_timeout = enable_1hz && (r_to == TW'(TIMEOUT_S - 1));

    always_comb begin
        w_next = r_state;
        w_eh_n = r_eh;
        w_em_n = r_em;
        case (r_state)
            IDLE: begin
                if (w_mode_ev) begin
                    w_next = EDIT_H;
                    w_eh_n = {cur_h_msd, cur_h_lsd};
                    w_em_n = {cur_m_msd, cur_m_lsd};
                end
            end
            EDIT_H: begin
                if (w_mode_ev)     w_next = EDIT_M;
                else if (w_inc_ev) w_eh_n = hour_inc(r_eh);
                else if (w_timeout) w_next = IDLE;
            end
            EDIT_M: begin
                if (w_mode_ev)     w_next = COMMIT;
                else if (w_inc_ev) w_em_n = min_inc(r_em);
                else if (w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load outputs are registered off next-state so they line up with r_state.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            r_eh    <= '0;
            r_em    <= '0;
            r_ld_h  <= '0;
            r_ld_m  <= '0;
            r_load  <= 1'b0;
            r_to    <= '0;
            r_phase <= 1'b0;
        end else begin
            r_eh   <= w_eh_n;
            r_em   <= w_em_n;
            r_ld_h <= (w_next != IDLE) ? w_eh_n : '0;
            r_ld_m <= (w_next != IDLE) ? w_em_n : '0;
            r_load <= (w_next == COMMIT);
            if (!w_editing || (w_next != r_state) || w_mode_ev || w_inc_ev) begin
                r_to <= '0;
            end else if (enable_1hz) begin
                r_to <= r_to + 1'b1;
            end
            if (!w_editing || (w_next != r_state)) begin
                r_phase <= 1'b0;
            end else if (enable_1hz) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign load        = r_load;
    assign ld_h_msd    = r_ld_h.msd;
    assign ld_h_lsd    = r_ld_h.lsd;
    assign ld_m_msd    = r_ld_m.msd;
    assign ld_m_lsd    = r_ld_m.lsd;
    assign edit_active = w_editing;
    assign blank_h     = (r_state == EDIT_H) & r_phase;
    assign blank_m     = (r_state == EDIT_M) & r_phase;

endmodule
`default_nettype wire

// File: tb/tb_set_time_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_set_time_ctrl : directed + random button/tick stimulus vs model |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_set_time_ctrl;

    localparam int DEB = 16;
    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       bm = 1'b0;
    logic       bi = 1'b0;
    logic [2:0] chm = '0, cmm = '0;
    logic [3:0] chl = '0, cml = '0;
    logic       load, edit_active, blank_h, blank_m;
    logic [2:0] ld_h_msd, ld_m_msd;
    logic [3:0] ld_h_lsd, ld_m_lsd;

    set_time_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
        .main_clock  (clk),
        .main_reset  (rst_n),
        .enable_1hz  (tick),
        .btn_mode    (bm),
        .btn_inc     (bi),
        .cur_h_msd   (chm),
        .cur_h_lsd   (chl),
        .cur_m_msd   (cmm),
        .cur_m_lsd   (cml),
        .load        (load),
        .ld_h_msd    (ld_h_msd),
        .ld_h_lsd    (ld_h_lsd),
        .ld_m_msd    (ld_m_msd),
        .ld_m_lsd    (ld_m_lsd),
        .edit_active (edit_active),
        .blank_h     (blank_h),
        .blank_m     (blank_m)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edit state 0=idle,1=hours,2=minutes; values as plain integers.
    int m_st = 0, m_h = 0, m_m = 0, m_to = 0, m_loads = 0, m_ld_h = 0, m_ld_m = 0;
    bit m_ph = 1'b0;

    int seen_loads = 0, seen_ld_h = 0, seen_ld_m = 0;

    always @(negedge clk) begin
        if (load) begin
            seen_loads++;
            seen_ld_h = int'(ld_h_msd) * 10 + int'(ld_h_lsd);
            seen_ld_m = int'(ld_m_msd) * 10 + int'(ld_m_lsd);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_h();
        return int'(ld_h_msd) * 10 + int'(ld_h_lsd);
    endfunction

    function automatic int out_m();
        return int'(ld_m_msd) * 10 + int'(ld_m_lsd);
    endfunction

    task automatic model_mode();
        case (m_st)
            0: begin
                m_h  = int'(chm) * 10 + int'(chl);
                m_m  = int'(cmm) * 10 + int'(cml);
                m_st = 1;
            end
            1: m_st = 2;
            default: begin
                m_loads++;
                m_ld_h = m_h;
                m_ld_m = m_m;
                m_st   = 0;
            end
        endcase
        m_to = 0;
        m_ph = 1'b0;
    endtask

    task automatic model_inc();
        if (m_st == 1) m_h = (m_h >= 23) ? 0 : m_h + 1;
        if (m_st == 2) m_m = (m_m >= 59) ? 0 : m_m + 1;
        if (m_st != 0) m_to = 0;
    endtask

    task automatic model_tick();
        if (m_st != 0) begin
            m_to++;
            if (m_to == TMO) begin
                m_st = 0;
                m_to = 0;
                m_ph = 1'b0;
            end else begin
                m_ph = ~m_ph;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".edit_active"}, int'(edit_active), int'(m_st != 0));
        check({tag, ".blank_h"}, int'(blank_h), int'(m_st == 1 && m_ph));
        check({tag, ".blank_m"}, int'(blank_m), int'(m_st == 2 && m_ph));
        check({tag, ".ld_h"}, out_h(), (m_st != 0) ? m_h : 0);
        check({tag, ".ld_m"}, out_m(), (m_st != 0) ? m_m : 0);
        check({tag, ".loads"}, seen_loads, m_loads);
        check({tag, ".last_ld"}, seen_ld_h * 100 + seen_ld_m, m_ld_h * 100 + m_ld_m);
    endtask

    task automatic press(input bit mode, input bit inc);
        @(negedge clk);
        bm = mode;
        bi = inc;
        repeat (DEB + 6) @(negedge clk);
        bm = 1'b0;
        bi = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        if (mode) model_mode();
        else if (inc) model_inc();
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        model_tick();
    endtask

    task automatic set_cur(input int h, input int m);
        chm = 3'(h / 10);
        chl = 4'(h % 10);
        cmm = 3'(m / 10);
        cml = 4'(m % 10);
    endtask

    task automatic goto_idle();
        for (int k = 0; k < 3 && m_st != 0; k++) press(1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst.edit_active", int'(edit_active), 0);
        check("rst.load", int'(load), 0);
        check("rst.ld", out_h() * 100 + out_m(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 12:34, mode press: exact event latency then blink on ticks
        set_cur(12, 34);
        bm = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1 check("lat.before", int'(edit_active), 0);
        @(posedge clk);
        #1 check("lat.after", int'(edit_active), 1);
        @(negedge clk);
        bm = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        model_mode();
        check_all("enter1234");
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            check_all("blink");
        end

        // Hour increment boundaries
        goto_idle();
        set_cur(23, 45); press(1'b1, 1'b0); press(1'b0, 1'b1);
        check("h23", out_h(), 0);
        check_all("h23");
        goto_idle();
        set_cur(19, 0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        check("h19", out_h(), 20);
        goto_idle();
        set_cur(9, 0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        check("h09", out_h(), 10);
        goto_idle();
        set_cur(25, 0); press(1'b1, 1'b0);
        check("h25copy", out_h(), 25);
        press(1'b0, 1'b1);
        check("h25norm", out_h(), 0);

        // Full edit sequence from 22:59 commits 00:00
        goto_idle();
        set_cur(22, 59);
        press(1'b1, 1'b0); press(1'b0, 1'b1); press(1'b0, 1'b1);
        press(1'b1, 1'b0); press(1'b0, 1'b1); press(1'b1, 1'b0);
        check("seq.ld", seen_ld_h * 100 + seen_ld_m, 0);
        check_all("seq");

        // Chatter then stable high gives exactly one increment
        set_cur(5, 7);
        press(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bi = ~bi;
        end
        repeat (DEB + 6) @(negedge clk);
        bi = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        model_inc();
        check("chatter", out_h(), 6);
        check_all("chatter");

        // Simultaneous mode+inc: state advances, value unchanged
        press(1'b1, 1'b1);
        check_all("simul");

        // Timeout in EDIT_M: no load
        for (int k = 0; k < TMO; k++) begin
            pulse_tick();
            check_all("timeout");
        end

        // Reset in EDIT_M takes effect immediately
        set_cur(8, 15);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid.edit_active", int'(edit_active), 0);
        check("rstmid.outs", out_h() * 100 + out_m() + int'(load) + int'(blank_m), 0);
        m_st = 0; m_to = 0; m_ph = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("rstmid");

`ifdef AUTO_REPEAT_EN
        set_cur(8, 10);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        @(negedge clk);
        bi = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        model_inc();
        for (int k = 1; k <= 5; k++) begin
            pulse_tick();
            if (k >= 3) model_inc();
            check_all("repeat");
        end
        bi = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        check("repeat.m", out_m(), 14);
`endif

        // Randomized button/tick sequences
        for (int n = 0; n < 120; n++) begin
            int op;
            op = int'($urandom_range(0, 99));
            if (m_st == 0) set_cur(int'($urandom_range(0, 39)), int'($urandom_range(0, 79)));
            if (op < 35) begin
                pulse_tick();
            end else if (op < 60) begin
                press(1'b1, 1'b0);
            end else if (op < 92) begin
                press(1'b0, 1'b1);
            end else if (op < 96) begin
                press(1'b1, 1'b1);
            end else begin
                for (int k = 0; k < TMO; k++) pulse_tick();
            end
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
